// File: rtl/nfir_pkg.sv
// nfir_pkg: sizing helpers and fixed-point arithmetic shared by the nfir_ntap filter
package nfir_pkg;

    typedef logic signed [127:0] wide_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + clog2(n);
    endfunction

    function automatic int latency(input int n);
        return 3 + clog2(n);
    endfunction

    function automatic wide_t round_const(input int frac);
        return frac > 0 ? wide_t'(1) <<< (frac - 1) : '0;
    endfunction

    function automatic wide_t saturate(input wide_t v, input int dw, output logic sat);
        wide_t hi, lo;
        hi = (wide_t'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        sat = v > hi || v < lo;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/nfir_adder_tree.sv
// nfir_adder_tree: pipelined binary adder tree, one register per level, leaves zero-padded to a power of two
module nfir_adder_tree
    import nfir_pkg::*;
#(
    parameter int LEAVES = 16,
    parameter int W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic [LEAVES*W-1:0] leaves,
    output logic out_valid,
    output logic signed [W+clog2(LEAVES)-1:0] sum
);
    localparam int L = clog2(LEAVES);
    localparam int P = 1 << L;
    localparam int OW = W + L;

    logic signed [OW-1:0] leaf [P];
    logic signed [OW-1:0] node [1:P-1];
    logic [L-1:0] vp;

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < LEAVES) begin : g_used
            assign leaf[i] = OW'(signed'(leaves[i*W +: W]));
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    for (genvar i = 1; i < P; i++) begin : g_node
        logic signed [OW-1:0] a, b;
        if (2 * i >= P) begin : g_bottom
            assign a = leaf[2*i-P];
            assign b = leaf[2*i+1-P];
        end else begin : g_inner
            assign a = node[2*i];
            assign b = node[2*i+1];
        end
        // each node registers the sum of its two children
        always_ff @(posedge clk)
            if (rst) node[i] <= '0;
            else if (en) node[i] <= a + b;
    end

    // valid flag walks the same number of levels as the data
    always_ff @(posedge clk)
        if (rst) vp <= '0;
        else if (en) vp <= L'({vp, in_valid});

    assign sum = node[1];
    assign out_valid = vp[L-1];

endmodule

// File: rtl/nfir_ntap.sv
// nfir_ntap: pipelined N-tap FIR with rounding, saturation and writable coefficient bank
// Optional macro NFIR_SAT_CNT_EN adds a sticky 16-bit sat_count output.
module nfir_ntap
    import nfir_pkg::*;
#(
    parameter int N_TAPS = 16,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int FRAC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in_valid,
    input  logic [DW-1:0] x_in,
    input  logic coef_we,
    input  logic [5:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic out_valid,
    output logic [DW-1:0] y_out,
    output logic sat_out
`ifdef NFIR_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int L = latency(N_TAPS) - 3;
    localparam int PW = DW + CW;
    localparam int AW = acc_width(DW, CW, N_TAPS);

    logic signed [CW-1:0] h [N_TAPS];
    logic signed [DW-1:0] dl [N_TAPS-1];
    logic signed [DW-1:0] tap [N_TAPS];
    logic signed [DW-1:0] x_r;
    logic v_r, m_v, t_v, sat_c;
    logic [N_TAPS*PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic [DW-1:0] y_c;

    // coefficient bank accepts writes whether or not the pipeline is enabled
    always_ff @(posedge clk)
        if (rst) for (int k = 0; k < N_TAPS; k++) h[k] <= '0;
        else if (coef_we && int'(coef_addr) < N_TAPS) h[coef_addr[L-1:0]] <= coef_wdata;

    // input register
    always_ff @(posedge clk)
        if (rst) begin
            x_r <= '0;
            v_r <= 1'b0;
        end else if (enable) begin
            x_r <= x_in;
            v_r <= in_valid;
        end

    // history only advances on accepted samples
    always_ff @(posedge clk)
        if (rst) for (int k = 0; k < N_TAPS - 1; k++) dl[k] <= '0;
        else if (enable && v_r) begin
            dl[0] <= x_r;
            for (int k = 1; k < N_TAPS - 1; k++) dl[k] <= dl[k-1];
        end

    // newest sample sits in the input register, older ones in the delay line
    always_comb begin
        tap[0] = x_r;
        for (int k = 1; k < N_TAPS; k++) tap[k] = dl[k-1];
    end

    // full-precision products, one per tap
    always_ff @(posedge clk)
        if (rst) begin
            prod <= '0;
            m_v <= 1'b0;
        end else if (enable) begin
            m_v <= v_r;
            for (int k = 0; k < N_TAPS; k++) prod[k*PW +: PW] <= PW'(h[k]) * PW'(tap[k]);
        end

    nfir_adder_tree #(.LEAVES(N_TAPS), .W(PW)) u_tree (
        .clk(clk),
        .rst(rst),
        .en(enable),
        .in_valid(m_v),
        .leaves(prod),
        .out_valid(t_v),
        .sum(acc)
    );

    // round half-up, drop FRAC bits, clip to the output range
    always_comb y_c = DW'(saturate((wide_t'(acc) + round_const(FRAC)) >>> FRAC, DW, sat_c));

    // output stage: value and clip flag change only with a new result
    always_ff @(posedge clk)
        if (rst) begin
            out_valid <= 1'b0;
            y_out <= '0;
            sat_out <= 1'b0;
        end else if (enable) begin
            out_valid <= t_v;
            if (t_v) begin
                y_out <= y_c;
                sat_out <= sat_c;
            end
        end

`ifdef NFIR_SAT_CNT_EN
    // sticky count of clipped results
    always_ff @(posedge clk)
        if (rst) sat_count <= '0;
        else if (enable && t_v && sat_c && sat_count != 16'hffff) sat_count <= sat_count + 16'd1;
`endif

endmodule

// File: tb/tb_nfir_ntap.sv
// tb_nfir_ntap: directed tables plus randomized traffic against a sample-level reference model
module tb_nfir_ntap;
    localparam int N = 16;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FRAC = 15;

    logic clk, rst, enable, in_valid, coef_we, out_valid, sat_out;
    logic signed [DW-1:0] x_in, y_out;
    logic [5:0] coef_addr;
    logic signed [CW-1:0] coef_wdata;
`ifdef NFIR_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    nfir_ntap #(.N_TAPS(N), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in_valid(in_valid),
        .x_in(x_in),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_wdata(coef_wdata),
        .out_valid(out_valid),
        .y_out(y_out),
        .sat_out(sat_out)
`ifdef NFIR_SAT_CNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk = 0;
    int imp[16] = '{32, 64, 128, 256, 512, 1024, 2048, 4096, 4096, 2048, 1024, 512, 256, 128, 64, 32};

    // reference model: sample history, coefficient copy, and a queue of results due at a given enabled cycle
    typedef struct {longint due; int y; bit s;} exp_t;
    exp_t q[$];
    int mh[N];
    int hist[N];
    bit p_v;
    int p_x;
    longint p_due;
    longint ecyc = 0;
    bit m_ov, m_s;
    int m_y, m_cnt;

    typedef struct {int x; bit v; bit ov; int y;} vec_t;
    vec_t tbl[26];

    task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_edge(bit en, bit v, int x, bit we, int addr, int wd, bit r);
        longint acc, rr;
        if (r) begin
            foreach (mh[k]) mh[k] = 0;
            foreach (hist[k]) hist[k] = 0;
            q.delete();
            p_v = 0;
            m_ov = 0;
            m_y = 0;
            m_s = 0;
            m_cnt = 0;
            return;
        end
        if (en) begin
            ecyc++;
            if (q.size() > 0 && q[0].due == ecyc) begin
                m_ov = 1;
                m_y = q[0].y;
                m_s = q[0].s;
                void'(q.pop_front());
                if (m_s && m_cnt < 65535) m_cnt++;
            end else m_ov = 0;
            if (p_v) begin
                for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = p_x;
                acc = 0;
                for (int k = 0; k < N; k++) acc += longint'(mh[k]) * longint'(hist[k]);
                rr = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
                q.push_back('{p_due,
                              rr > 32767 ? 32767 : rr < -32768 ? -32768 : int'(rr),
                              rr > 32767 || rr < -32768});
            end
            p_v = v;
            p_x = x;
            p_due = ecyc + 6;
        end
        if (we && addr < N) mh[addr] = wd;
    endtask

    task automatic step(bit en, bit v, int x, bit we = 0, int addr = 0, int wd = 0, bit r = 0);
        rst = r;
        enable = en;
        in_valid = v;
        x_in = DW'(x);
        coef_we = we;
        coef_addr = 6'(addr);
        coef_wdata = CW'(wd);
        model_edge(en, v, x, we, addr, wd, r);
        @(posedge clk);
        #1;
        chk("model_out_valid", out_valid, m_ov);
        chk("model_y_out", y_out, m_y);
        chk("model_sat_out", sat_out, m_s);
`ifdef NFIR_SAT_CNT_EN
        chk("model_sat_count", sat_count, m_cnt);
`endif
    endtask

    task automatic load_coefs();
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1, k, 64 << k);
            step(0, 0, 0, 1, 15 - k, 64 << k);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int got[$];
        int y;
        bit en;
        // reset state
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1234, 0, 0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_sat_out", sat_out, 0);
        load_coefs();

        // impulse response table
        for (int i = 0; i < 26; i++) begin
            tbl[i].x = i == 0 ? 16384 : 0;
            tbl[i].v = 1;
            tbl[i].ov = i + 1 >= 7;
            tbl[i].y = (i + 1 >= 7 && i + 1 - 7 < 16) ? imp[i+1-7] : 0;
        end
        foreach (tbl[i]) begin
            step(1, tbl[i].v, tbl[i].x);
            chk("imp_out_valid", out_valid, tbl[i].ov);
            chk("imp_y_out", y_out, tbl[i].y);
        end

        // step response
        for (int i = 0; i < 40; i++) step(1, 1, 32767);
        chk("step_y_out", y_out, 32639);
        chk("step_sat_out", sat_out, 0);

        // freeze in the middle of an impulse
        step(1, 0, 0, 0, 0, 0, 1);
        load_coefs();
        for (int i = 0; i < 50; i++) begin
            en = !(i >= 10 && i < 20);
            step(en, i == 0 ? 1'b1 : (en ? 1'b1 : 1'($urandom_range(1))), (i == 0) ? 16384 : (en ? 0 : rnd16()));
            if (en && out_valid) got.push_back(int'(y_out));
        end
        chk("freeze_count", got.size() >= 17, 1);
        for (int k = 0; k < 17 && k < got.size(); k++) chk("freeze_y_out", got[k], k < 16 ? imp[k] : 0);

        // hot coefficient writes
        step(1, 0, 0, 0, 0, 0, 1);
        load_coefs();
        for (int i = 0; i < 30; i++) step(1, 1, 16384);
        chk("hot_settle", y_out, 16320);
        step(1, 1, 16384, 1, 40, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 16384);
            chk("hot_addr40", y_out, 16320);
        end
        step(1, 1, 16384, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 16384);
            chk("hot_h0", y_out, k < 6 ? 16320 : 16288);
        end

        // saturation both ways
        step(1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < N; k++) step(0, 0, 0, 1, k, 32767);
        for (int i = 0; i < 25; i++) step(1, 1, 32767);
        chk("sat_pos_y", y_out, 32767);
        chk("sat_pos_flag", sat_out, 1);
        for (int i = 0; i < 25; i++) step(1, 1, -32768);
        chk("sat_neg_y", y_out, -32768);
        chk("sat_neg_flag", sat_out, 1);

        // reset in the middle of a stream
        load_coefs();
        for (int i = 0; i < 20; i++) step(1, 1, rnd16());
        step(1'($urandom_range(1)), 1, rnd16(), 0, 0, 0, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y_out", y_out, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, rnd16());
            chk("postrst_y_out", y_out, 0);
            chk("postrst_sat_out", sat_out, 0);
        end

        // randomized traffic
        for (int k = 0; k < N; k++) step(0, 0, 0, 1, k, rnd16() >>> 3);
        for (int i = 0; i < 600; i++) begin
            y = rnd16();
            step($urandom_range(4) != 0, $urandom_range(9) < 7, y,
                 $urandom_range(19) == 0, int'($urandom_range(63)), rnd16() >>> 2,
                 $urandom_range(149) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nfir_ntap.md
NFIR_NTAP -- requirements
Module: nfir_ntap

Interface
REQ-001 SHALL expose parameters: N_TAPS, default 16, tap count (2..64); DW, default 16, sample width; CW, default 16, coefficient width; FRAC, default 15, fractional bits dropped at output.
REQ-002 SHALL expose ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance; 0 freezes every register except the coefficient bank.
- in_valid  in  1  x_in carries a sample this cycle.
- x_in  in  DW  signed sample, Q1.(DW-1).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  tap index to write.
- coef_wdata  in  CW  signed coefficient.
- out_valid  out  1  y_out carries a new result.
- y_out  out  DW  signed filtered sample.
- sat_out  out  1  current y_out was clipped.

Function
REQ-003 SHALL compute y = sat_DW((sum over k of h[k]*x[n-k] + 2^(FRAC-1)) >>> FRAC), k = 0..N_TAPS-1, with arithmetic shift, round-half-up.
REQ-004 Accumulator width SHALL be DW+CW+clog2(N_TAPS); no intermediate overflow or truncation.
REQ-005 Saturation SHALL clip to [-2^(DW-1), 2^(DW-1)-1]; sat_out=1 on the same cycle as that y_out, else 0.
REQ-006 Pipeline SHALL be: input register, multiply register, clog2(N_TAPS) registered adder levels, round/saturate register; LATENCY = 3+clog2(N_TAPS) enabled cycles (7 at N_TAPS=16).
REQ-007 Delay line SHALL shift only when enable=1 and the registered input is valid; invalid cycles leave history untouched.
REQ-008 A valid flag SHALL travel alongside the data pipeline; out_valid = flag at output stage, asserted exactly LATENCY enabled cycles after the accepted in_valid.
REQ-009 With enable=0 all pipeline, valid, y_out and sat_out registers SHALL hold; x_in and in_valid are ignored.
REQ-010 y_out and sat_out SHALL update only when out_valid is asserted; otherwise they hold their last value.
REQ-011 Coefficient writes SHALL be accepted regardless of enable; coef_addr >= N_TAPS SHALL be ignored.
REQ-012 A coefficient written in cycle t SHALL be used by the multiply stage from cycle t+1; a sample in the multiply stage at t uses the old value.
REQ-013 Back-to-back in_valid SHALL be sustained at full throughput, one result per enabled cycle.

Reset
REQ-014 rst=1 SHALL clear delay line, all pipeline stages, valid flags, coefficient bank, y_out=0, out_valid=0, sat_out=0, on the next edge, regardless of enable.
REQ-015 Reset mid-stream SHALL discard all in-flight samples; no out_valid until LATENCY cycles after the first post-reset valid input.

Configuration
REQ-016 Macro NFIR_SAT_CNT_EN SHALL add output sat_count (16 bits): counts sat_out assertions and sticks at 65535; clears on rst.
REQ-017 Without NFIR_SAT_CNT_EN, port sat_count and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-018 Package nfir_pkg SHALL hold: clog2 function, accumulator-width and LATENCY calculations, rounding-constant function, and the saturate function.
REQ-019 Adder tree SHALL be a sub-module nfir_adder_tree, parametrised on leaf count and width, zero-padding to a power of two, one register per level, honouring enable.

Verification
REQ-020 Benches SHALL run N_TAPS=16, DW=CW=16, FRAC=15, coefficients {64,128,256,512,1024,2048,4096,8192} mirrored, unless stated otherwise.
REQ-021 Impulse: one x_in=16384 then zeros -> from cycle 7, y_out = 32,64,...,4096,4096,...,32 on 16 consecutive out_valid cycles, then 0.
REQ-022 Step: x_in=32767 continuous -> y_out settles at 32639, sat_out=0.
REQ-023 Saturation: all coefficients 32767; x_in=32767 -> y_out=32767, sat_out=1; x_in=-32768 -> y_out=-32768, sat_out=1; with NFIR_SAT_CNT_EN, sat_count increments per clipped output.
REQ-024 Freeze: enable=0 for 10 cycles with random x_in mid-impulse -> outputs hold; the remaining sequence resumes unaltered after enable=1.
REQ-025 Hot coefficient write: write h[0]=0 during a 16384 step; the output drops by 32 exactly on the result whose multiply stage follows the write, and a write to coef_addr=40 has no effect.
REQ-026 Reset mid-stream: rst pulse during random input -> y_out=0 and out_valid=0 immediately, coefficients zero, and all outputs 0 until reload.
